generic_cache: RTL and testbench
================================

Name: generic_cache

Overview:
Parameterised set-associative, write-back, write-allocate cache, one level of a memory hierarchy. Higher-level side (hc_*): 64-bit word requests from a core or upper cache. Lower-level side (lc_*): 512-bit line fill and writeback transactions to the next level. Blocking: one outstanding request at a time.

Parameters:
W, 64, address and word width in bits
B, 64, line size in bytes (line = 8*B = 512 bits)
C, 16384, capacity in bytes
NUM_WAYS, 4, associativity (sets = C/(B*NUM_WAYS) = 64; offset addr[5:0], index addr[11:6], tag addr[W-1:12])

Ports:
clk_in  in  1  clock
rst_N_in  in  1  reset; synchronous, active-high
cs_in  in  1  chip select; 0 = accept no new requests
flush_in  in  1  request writeback of dirty lines and invalidation of all lines
hc_valid_in  in  1  upper request valid
hc_ready_in  in  1  upper ready to take response
hc_addr_in  in  W  request byte address
hc_value_in  in  W  write data
hc_we_in  in  1  1 = write, 0 = read
lc_valid_out  out  1  lower request valid
lc_ready_out  out  1  ready to accept fill data
lc_addr_out  out  W  line-aligned lower address
lc_value_out  out  8*B  writeback line data
we_out  out  1  1 = writeback, 0 = fill read
lc_valid_in  in  1  fill data valid
lc_ready_in  in  1  lower accepts request
lc_addr_in  in  W  fill address (ignored; single outstanding)
lc_value_in  in  8*B  fill line data
hc_valid_out  out  1  response valid
hc_ready_out  out  1  cache can accept a request
hc_we_out  out  1  response is a write acknowledgement
hc_addr_out  out  W  address of responded request
hc_value_out  out  W  read data, or written data on write ack
cl_in  in  1  reserved; no effect
cache_line_in  in  8*B  reserved; no effect

Behaviour:
- Reset (rst_N_in=1 at clk edge): all valid/dirty bits and LRU state cleared; state IDLE; every output 0.
- States: IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT, RESP, FLUSH.
- IDLE: hc_ready_out = cs_in. hc_valid_in & hc_ready_out at an edge latches addr, value and we; next state LOOKUP. flush_in in IDLE (priority over a request) -> FLUSH.
- LOOKUP: compare tag against every valid way of the indexed set.
  - Hit, read: select word addr[5:3] (word 0 = line bits 63:0).
  - Hit, write: replace that word and set dirty.
  - Hit -> RESP; update LRU.
  - Miss: victim = lowest-numbered invalid way, else LRU way. Dirty victim -> WRITEBACK; clean victim -> FILL_REQ.
- WRITEBACK: lc_valid_out=1, we_out=1, lc_addr_out = victim tag/index with offset 0, lc_value_out = victim line. Held until lc_ready_in, then -> FILL_REQ.
- FILL_REQ: lc_valid_out=1, we_out=0, lc_addr_out = request address with addr[5:0]=0. Held until lc_ready_in, then -> FILL_WAIT.
- FILL_WAIT: lc_ready_out=1 until lc_valid_in. Install lc_value_in in the victim way: valid=1, dirty=0, new tag. A pending write merges its word and sets dirty. Update LRU; -> RESP.
- RESP: hc_valid_out=1; hc_addr_out = request address; hc_we_out = request we; hc_value_out = read word or written data. Held until hc_ready_in, then -> IDLE.
- hc_value_out/hc_addr_out keep their last values after hc_valid_out drops.
- Hit latency: accept edge T, hc_valid_out high after edge T+2.
- Miss latency: bounded by the lower-level handshakes.
- FLUSH: walk sets/ways in order. Each dirty valid line is written back via the WRITEBACK handshake. Then clear all valid/dirty bits -> IDLE.
- Inputs with no effect: hc_valid_in outside IDLE; lc_valid_in outside FILL_WAIT.
- LRU is true LRU per set, using age counters.

Decomposition:
- cache_pkg: state enum; derived localparams (offset/index/tag widths, NUM_SETS, WORDS_PER_LINE); tag-entry struct {valid, dirty, tag}.
- Sub-module lru_tracker: per-set ages; touch(way), victim(way) outputs.

Test Plan:
- Read miss at 0x0, fill 512'h0123456789ABCDEF -> lc_valid_out=1, we_out=0, lc_addr_out=0x0; subsequent read 0x0 hits and returns 0x0123456789ABCDEF with no lc traffic.
- Reads of 0x4000, 0x34000, 0x44000 (same set 0), filled with 512'h0CAD456789AACDEF, 512'h0DEADBEEF12345678, 512'h0CAD456789AACDEF -> each misses, then hits with the low word; 0x0 is still resident.
- Read 0x54, fill 512'hDEADBEEFDEADBEEF -> lc_addr_out=0x40; read 0x40 returns 0xDEADBEEFDEADBEEF.
- Write 0x0 with 0xFEDCBA9876543210 -> hit, no lc_valid_out, write ack; following read 0x0 returns 0xFEDCBA9876543210.
- Fifth distinct tag in set 0 -> LRU victim evicted; if dirty, writeback (we_out=1, its line data) precedes the fill.
- flush_in after dirty writes -> one writeback per dirty line; afterwards a read of 0x0 misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and default geometry for the generic set-associative cache.
package cache_pkg;

    // Default geometry; the top recomputes its own widths from its parameters.
    localparam int unsigned DEF_W          = 64;
    localparam int unsigned DEF_B          = 64;
    localparam int unsigned DEF_C          = 16384;
    localparam int unsigned DEF_NUM_WAYS   = 4;
    localparam int unsigned LINE_W         = 8 * DEF_B;
    localparam int unsigned OFFSET_W       = $clog2(DEF_B);
    localparam int unsigned NUM_SETS       = DEF_C / (DEF_B * DEF_NUM_WAYS);
    localparam int unsigned INDEX_W        = $clog2(NUM_SETS);
    localparam int unsigned TAG_W          = DEF_W - OFFSET_W - INDEX_W;
    localparam int unsigned WORDS_PER_LINE = LINE_W / DEF_W;
    // Tag field is sized for the widest address so any W up to 64 fits.
    localparam int unsigned MAX_TAG_W      = 64;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWriteback,
        StFillReq,
        StFillWait,
        StResp,
        StFlush
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [MAX_TAG_W-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/lru_tracker.sv
// True-LRU tracker: one age counter per way per set, age 0 = most recent.
module lru_tracker #(
    parameter int unsigned NUM_SETS = 64,
    parameter int unsigned NUM_WAYS = 4,
    localparam int unsigned SET_W = $clog2(NUM_SETS),
    localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             touch,
    input  logic [SET_W-1:0] touch_set,
    input  logic [WAY_W-1:0] touch_way,
    input  logic [SET_W-1:0] query_set,
    output logic [WAY_W-1:0] victim
);

    logic [WAY_W-1:0] age [NUM_SETS][NUM_WAYS];

    // Touched way becomes youngest; ways no older than it age by one (saturating),
    // which also spreads the all-zero reset state into a proper ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age[s][w] <= '0;
                end
            end
        end else if (touch) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == touch_way) begin
                    age[touch_set][w] <= '0;
                end else if (age[touch_set][w] <= age[touch_set][touch_way] &&
                             age[touch_set][w] != WAY_W'(NUM_WAYS - 1)) begin
                    age[touch_set][w] <= age[touch_set][w] + 1'b1;
                end
            end
        end
    end

    // Oldest way of the queried set; lowest index wins ties.
    always_comb begin
        logic [WAY_W-1:0] best;
        best = '0;
        for (int w = 1; w < NUM_WAYS; w++) begin
            if (age[query_set][w] > age[query_set][best]) begin
                best = WAY_W'(w);
            end
        end
        victim = best;
    end

endmodule

// File: rtl/generic_cache.sv
// Blocking set-associative write-back, write-allocate cache with flush.
module generic_cache
    import cache_pkg::*;
#(
    parameter int unsigned W        = 64,
    parameter int unsigned B        = 64,
    parameter int unsigned C        = 16384,
    parameter int unsigned NUM_WAYS = 4
) (
    input  logic           clk_in,
    input  logic           rst_N_in,
    input  logic           cs_in,
    input  logic           flush_in,
    input  logic           hc_valid_in,
    input  logic           hc_ready_in,
    input  logic [W-1:0]   hc_addr_in,
    input  logic [W-1:0]   hc_value_in,
    input  logic           hc_we_in,
    output logic           lc_valid_out,
    output logic           lc_ready_out,
    output logic [W-1:0]   lc_addr_out,
    output logic [8*B-1:0] lc_value_out,
    output logic           we_out,
    input  logic           lc_valid_in,
    input  logic           lc_ready_in,
    input  logic [W-1:0]   lc_addr_in,
    input  logic [8*B-1:0] lc_value_in,
    output logic           hc_valid_out,
    output logic           hc_ready_out,
    output logic           hc_we_out,
    output logic [W-1:0]   hc_addr_out,
    output logic [W-1:0]   hc_value_out,
    input  logic           cl_in,
    input  logic [8*B-1:0] cache_line_in
);

    localparam int unsigned LINE_BITS = 8 * B;
    localparam int unsigned OFF_BITS  = $clog2(B);
    localparam int unsigned SET_CNT   = C / (B * NUM_WAYS);
    localparam int unsigned IDX_BITS  = $clog2(SET_CNT);
    localparam int unsigned TAG_BITS  = W - OFF_BITS - IDX_BITS;
    localparam int unsigned WORD_CNT  = LINE_BITS / W;
    localparam int unsigned WSEL_BITS = $clog2(WORD_CNT);
    localparam int unsigned BOFF_BITS = $clog2(W / 8);
    localparam int unsigned WAY_BITS  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    state_t state_q, state_d;

    tag_entry_t           tags [SET_CNT][NUM_WAYS];
    logic [LINE_BITS-1:0] data [SET_CNT][NUM_WAYS];

    logic [W-1:0]   req_addr_q, req_value_q, resp_addr_q, resp_value_q;
    logic           req_we_q, lookup_done_q, hit_q, flushing_q;
    logic [WAY_BITS-1:0] way_q;
    logic [IDX_BITS+WAY_BITS-1:0] flush_ptr_q;

    logic [IDX_BITS-1:0]  req_idx, flush_set, wb_set;
    logic [TAG_BITS-1:0]  req_tag;
    logic [WSEL_BITS-1:0] req_word;
    logic [WAY_BITS-1:0]  flush_way, wb_way, hit_way, inv_way, lru_victim, pick_way;
    logic                 hit, inv_found;
    tag_entry_t           wb_entry;
    logic [LINE_BITS-1:0] fill_line;
    logic [W-1:0]         hit_word;
    logic accept, lookup_sample, hit_update, install, wb_done, flush_step, flush_clear;

    logic unused_inputs;
    assign unused_inputs = ^{cl_in, cache_line_in, lc_addr_in};

    assign req_idx   = req_addr_q[OFF_BITS +: IDX_BITS];
    assign req_tag   = req_addr_q[W-1 -: TAG_BITS];
    assign req_word  = req_addr_q[BOFF_BITS +: WSEL_BITS];
    assign flush_set = flush_ptr_q[WAY_BITS +: IDX_BITS];
    assign flush_way = flush_ptr_q[WAY_BITS-1:0];
    // Writeback source is the flush walk pointer or the miss victim.
    assign wb_set    = flushing_q ? flush_set : req_idx;
    assign wb_way    = flushing_q ? flush_way : way_q;
    assign wb_entry  = tags[wb_set][wb_way];
    assign hit_word  = data[req_idx][way_q][req_word*W +: W];
    assign pick_way  = hit ? hit_way : (inv_found ? inv_way : lru_victim);
    assign hc_addr_out  = resp_addr_q;
    assign hc_value_out = resp_value_q;

    lru_tracker #(
        .NUM_SETS (SET_CNT),
        .NUM_WAYS (NUM_WAYS)
    ) u_lru (
        .clk       (clk_in),
        .rst       (rst_N_in),
        .touch     (hit_update | install),
        .touch_set (req_idx),
        .touch_way (way_q),
        .query_set (req_idx),
        .victim    (lru_victim)
    );

    // Tag compare across the indexed set, plus first invalid way for allocation.
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        inv_found = 1'b0;
        inv_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && tags[req_idx][w].valid &&
                tags[req_idx][w].tag == MAX_TAG_W'(req_tag)) begin
                hit = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!inv_found && !tags[req_idx][w].valid) begin
                inv_found = 1'b1;
                inv_way = WAY_BITS'(w);
            end
        end
    end

    // Incoming fill line with a pending write word merged in.
    always_comb begin
        fill_line = lc_value_in;
        if (req_we_q) fill_line[req_word*W +: W] = req_value_q;
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_N_in) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Next state, handshake outputs and datapath strobes.
    always_comb begin
        state_d = state_q;
        hc_ready_out = 1'b0;
        hc_valid_out = 1'b0;
        hc_we_out = 1'b0;
        lc_valid_out = 1'b0;
        lc_ready_out = 1'b0;
        we_out = 1'b0;
        lc_addr_out = '0;
        lc_value_out = '0;
        accept = 1'b0;
        lookup_sample = 1'b0;
        hit_update = 1'b0;
        install = 1'b0;
        wb_done = 1'b0;
        flush_step = 1'b0;
        flush_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                hc_ready_out = cs_in;
                if (flush_in) begin
                    state_d = StFlush;
                end else if (hc_valid_in && cs_in) begin
                    accept = 1'b1;
                    state_d = StLookup;
                end
            end
            // First cycle registers the compare result, second acts on it.
            StLookup: begin
                if (!lookup_done_q) begin
                    lookup_sample = 1'b1;
                end else if (hit_q) begin
                    hit_update = 1'b1;
                    state_d = StResp;
                end else if (tags[req_idx][way_q].valid && tags[req_idx][way_q].dirty) begin
                    state_d = StWriteback;
                end else begin
                    state_d = StFillReq;
                end
            end
            StWriteback: begin
                lc_valid_out = 1'b1;
                we_out = 1'b1;
                lc_addr_out = {wb_entry.tag[TAG_BITS-1:0], wb_set, OFF_BITS'(0)};
                lc_value_out = data[wb_set][wb_way];
                if (lc_ready_in) begin
                    wb_done = 1'b1;
                    state_d = flushing_q ? StFlush : StFillReq;
                end
            end
            StFillReq: begin
                lc_valid_out = 1'b1;
                lc_addr_out = {req_addr_q[W-1:OFF_BITS], OFF_BITS'(0)};
                if (lc_ready_in) state_d = StFillWait;
            end
            StFillWait: begin
                lc_ready_out = 1'b1;
                if (lc_valid_in) begin
                    install = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                hc_valid_out = 1'b1;
                hc_we_out = req_we_q;
                if (hc_ready_in) state_d = StIdle;
            end
            StFlush: begin
                if (tags[flush_set][flush_way].valid && tags[flush_set][flush_way].dirty) begin
                    state_d = StWriteback;
                end else if (flush_ptr_q == '1) begin
                    flush_clear = 1'b1;
                    state_d = StIdle;
                end else begin
                    flush_step = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Request, tag and response registers.
    always_ff @(posedge clk_in) begin
        if (rst_N_in) begin
            for (int s = 0; s < SET_CNT; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) tags[s][w] <= '0;
            end
            req_addr_q <= '0;
            req_value_q <= '0;
            req_we_q <= 1'b0;
            lookup_done_q <= 1'b0;
            hit_q <= 1'b0;
            way_q <= '0;
            flushing_q <= 1'b0;
            flush_ptr_q <= '0;
            resp_addr_q <= '0;
            resp_value_q <= '0;
        end else begin
            if (accept) begin
                req_addr_q <= hc_addr_in;
                req_value_q <= hc_value_in;
                req_we_q <= hc_we_in;
                lookup_done_q <= 1'b0;
            end
            if (lookup_sample) begin
                lookup_done_q <= 1'b1;
                hit_q <= hit;
                way_q <= pick_way;
            end
            if (hit_update) begin
                if (req_we_q) tags[req_idx][way_q].dirty <= 1'b1;
                resp_value_q <= req_we_q ? req_value_q : hit_word;
                resp_addr_q <= req_addr_q;
            end
            if (install) begin
                tags[req_idx][way_q] <= '{valid: 1'b1, dirty: req_we_q,
                                          tag: MAX_TAG_W'(req_tag)};
                resp_value_q <= fill_line[req_word*W +: W];
                resp_addr_q <= req_addr_q;
            end
            if (state_q == StIdle && flush_in) flushing_q <= 1'b1;
            // Cleaned line is re-examined by the walk and then skipped.
            if (wb_done && flushing_q) tags[wb_set][wb_way].dirty <= 1'b0;
            if (flush_step) flush_ptr_q <= flush_ptr_q + 1'b1;
            if (flush_clear) begin
                for (int s = 0; s < SET_CNT; s++) begin
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        tags[s][w].valid <= 1'b0;
                        tags[s][w].dirty <= 1'b0;
                    end
                end
                flush_ptr_q <= '0;
                flushing_q <= 1'b0;
            end
        end
    end

    // Line storage: word update on write hit, whole line on fill.
    always_ff @(posedge clk_in) begin
        if (hit_update && req_we_q) data[req_idx][way_q][req_word*W +: W] <= req_value_q;
        if (install) data[req_idx][way_q] <= fill_line;
    end

endmodule

// File: tb/tb_generic_cache.sv
// Directed bench for generic_cache with a hand-driven lower level.
module tb_generic_cache;

    logic         clk_in = 1'b0;
    logic         rst_N_in, cs_in, flush_in;
    logic         hc_valid_in, hc_ready_in, hc_we_in;
    logic [63:0]  hc_addr_in, hc_value_in;
    logic         lc_valid_out, lc_ready_out, we_out;
    logic [63:0]  lc_addr_out;
    logic [511:0] lc_value_out;
    logic         lc_valid_in, lc_ready_in;
    logic [63:0]  lc_addr_in;
    logic [511:0] lc_value_in;
    logic         hc_valid_out, hc_ready_out, hc_we_out;
    logic [63:0]  hc_addr_out, hc_value_out;
    logic         cl_in;
    logic [511:0] cache_line_in;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    generic_cache dut (
        .clk_in        (clk_in),
        .rst_N_in      (rst_N_in),
        .cs_in         (cs_in),
        .flush_in      (flush_in),
        .hc_valid_in   (hc_valid_in),
        .hc_ready_in   (hc_ready_in),
        .hc_addr_in    (hc_addr_in),
        .hc_value_in   (hc_value_in),
        .hc_we_in      (hc_we_in),
        .lc_valid_out  (lc_valid_out),
        .lc_ready_out  (lc_ready_out),
        .lc_addr_out   (lc_addr_out),
        .lc_value_out  (lc_value_out),
        .we_out        (we_out),
        .lc_valid_in   (lc_valid_in),
        .lc_ready_in   (lc_ready_in),
        .lc_addr_in    (lc_addr_in),
        .lc_value_in   (lc_value_in),
        .hc_valid_out  (hc_valid_out),
        .hc_ready_out  (hc_ready_out),
        .hc_we_out     (hc_we_out),
        .hc_addr_out   (hc_addr_out),
        .hc_value_out  (hc_value_out),
        .cl_in         (cl_in),
        .cache_line_in (cache_line_in)
    );

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request; the lower level answers fills with fill_line and accepts
    // requests after 'stall' cycles of holding lc_ready_in low.
    task automatic xact(input string name, input logic we, input logic [63:0] addr,
                        input logic [63:0] wval, input int stall,
                        input logic exp_wb, input logic [63:0] wb_addr,
                        input logic [511:0] wb_line, input logic exp_fill,
                        input logic [511:0] fill_line, input logic [63:0] exp_val);
        bit done = 0;
        bit wb_seen = 0;
        bit fill_seen = 0;
        bit order_ok = 1;
        int lat = -1;
        int stall_left = stall;
        @(negedge clk_in);
        hc_valid_in = 1'b1;
        hc_we_in = we;
        hc_addr_in = addr;
        hc_value_in = wval;
        @(negedge clk_in);
        hc_valid_in = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            lc_ready_in = 1'b0;
            lc_valid_in = 1'b0;
            if (hc_valid_out) begin
                lat = cyc;
                check_eq({name, " resp_we"}, hc_we_out, we);
                check_eq({name, " resp_addr"}, hc_addr_out, addr);
                check_eq({name, " resp_value"}, hc_value_out, exp_val);
                hc_ready_in = 1'b1;
                done = 1;
            end else if (lc_valid_out) begin
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    lc_ready_in = 1'b1;
                    if (we_out) begin
                        wb_seen = 1;
                        check_eq({name, " wb_addr"}, lc_addr_out, wb_addr);
                        check_eq({name, " wb_line"}, lc_value_out, wb_line);
                    end else begin
                        fill_seen = 1;
                        if (exp_wb && !wb_seen) order_ok = 0;
                        check_eq({name, " fill_addr"}, lc_addr_out, addr & ~64'h3F);
                    end
                end
            end else if (lc_ready_out) begin
                lc_valid_in = 1'b1;
                lc_value_in = fill_line;
            end
            @(negedge clk_in);
        end
        hc_ready_in = 1'b0;
        lc_ready_in = 1'b0;
        lc_valid_in = 1'b0;
        check_eq({name, " done"}, done, 1'b1);
        check_eq({name, " wb_seen"}, wb_seen, exp_wb);
        check_eq({name, " fill_seen"}, fill_seen, exp_fill);
        check_eq({name, " wb_before_fill"}, order_ok, 1'b1);
        if (!exp_fill) check_eq({name, " hit_latency"}, lat, 2);
        check_eq({name, " valid_dropped"}, hc_valid_out, 1'b0);
        check_eq({name, " value_held"}, hc_value_out, exp_val);
    endtask

    initial begin
        logic [511:0] l_0123, l_0cad, l_dead, l_beef, l_fedc, l_a5, wb_a, wb_b;
        logic [63:0]  fl_addr [2];
        logic [511:0] fl_line [2];
        int           wb_cnt;
        bit           fl_done;

        l_0123 = 512'h0123456789ABCDEF;
        l_0cad = 512'h0CAD456789AACDEF;
        l_dead = 512'h0DEADBEEF12345678;
        l_beef = 512'hDEADBEEFDEADBEEF;
        l_fedc = 512'hFEDCBA9876543210;
        l_a5   = 512'hA5A5A5A5A5A5A5A5;

        rst_N_in = 1'b1; cs_in = 1'b0; flush_in = 1'b0;
        hc_valid_in = 1'b0; hc_ready_in = 1'b0; hc_we_in = 1'b0;
        hc_addr_in = '0; hc_value_in = '0;
        lc_valid_in = 1'b0; lc_ready_in = 1'b0; lc_addr_in = '0; lc_value_in = '0;
        cl_in = 1'b0; cache_line_in = '0;

        repeat (3) @(negedge clk_in);
        check_eq("rst hc_ready", hc_ready_out, 1'b0);
        check_eq("rst hc_valid", hc_valid_out, 1'b0);
        check_eq("rst lc_valid", lc_valid_out, 1'b0);
        check_eq("rst lc_ready", lc_ready_out, 1'b0);
        check_eq("rst we_out", we_out, 1'b0);
        check_eq("rst lc_addr", lc_addr_out, 64'h0);
        check_eq("rst hc_value", hc_value_out, 64'h0);
        check_eq("rst hc_addr", hc_addr_out, 64'h0);
        rst_N_in = 1'b0;

        // Chip select low: request must be ignored.
        @(negedge clk_in);
        hc_valid_in = 1'b1; hc_addr_in = 64'h0;
        repeat (3) @(negedge clk_in);
        check_eq("cs0 hc_ready", hc_ready_out, 1'b0);
        check_eq("cs0 no lc", lc_valid_out, 1'b0);
        check_eq("cs0 no resp", hc_valid_out, 1'b0);
        hc_valid_in = 1'b0;
        cs_in = 1'b1;
        #1;
        check_eq("cs1 hc_ready", hc_ready_out, 1'b1);

        xact("rd0 miss", 0, 64'h0, 0, 3, 0, 0, 0, 1, l_0123, 64'h0123456789ABCDEF);
        xact("rd0 hit", 0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 64'h0123456789ABCDEF);
        xact("rd4000 miss", 0, 64'h4000, 0, 0, 0, 0, 0, 1, l_0cad, 64'h0CAD456789AACDEF);
        xact("rd4000 hit", 0, 64'h4000, 0, 0, 0, 0, 0, 0, 0, 64'h0CAD456789AACDEF);
        xact("rd34000 miss", 0, 64'h34000, 0, 0, 0, 0, 0, 1, l_dead, 64'hDEADBEEF12345678);
        xact("rd34000 hit", 0, 64'h34000, 0, 0, 0, 0, 0, 0, 0, 64'hDEADBEEF12345678);
        xact("rd44000 miss", 0, 64'h44000, 0, 0, 0, 0, 0, 1, l_0cad, 64'h0CAD456789AACDEF);
        xact("rd44000 hit", 0, 64'h44000, 0, 0, 0, 0, 0, 0, 0, 64'h0CAD456789AACDEF);
        xact("rd0 resident", 0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 64'h0123456789ABCDEF);
        // Word 2 of a line whose only nonzero data is in word 0.
        xact("rd54 miss", 0, 64'h54, 0, 0, 0, 0, 0, 1, l_beef, 64'h0);
        xact("rd40 hit", 0, 64'h40, 0, 0, 0, 0, 0, 0, 0, 64'hDEADBEEFDEADBEEF);
        xact("wr0 hit", 1, 64'h0, 64'hFEDCBA9876543210, 0, 0, 0, 0, 0, 0,
             64'hFEDCBA9876543210);
        xact("rd0 after wr", 0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 64'hFEDCBA9876543210);
        // Make way 0 (dirty tag 0) the LRU of set 0.
        xact("rd4000 again", 0, 64'h4000, 0, 0, 0, 0, 0, 0, 0, 64'h0CAD456789AACDEF);
        xact("rd34000 again", 0, 64'h34000, 0, 0, 0, 0, 0, 0, 0, 64'hDEADBEEF12345678);
        xact("rd44000 again", 0, 64'h44000, 0, 0, 0, 0, 0, 0, 0, 64'h0CAD456789AACDEF);
        xact("rd8000 evict", 0, 64'h8000, 0, 2, 1, 64'h0, l_fedc, 1, l_a5,
             64'hA5A5A5A5A5A5A5A5);
        xact("rd0 refetch", 0, 64'h0, 0, 0, 0, 0, 0, 1, l_fedc, 64'hFEDCBA9876543210);
        xact("wr4010 miss", 1, 64'h4010, 64'h5555666677778888, 0, 0, 0, 0, 1, l_0cad,
             64'h5555666677778888);
        xact("wr48 hit", 1, 64'h48, 64'h01230000ABCD0001, 0, 0, 0, 0, 0, 0,
             64'h01230000ABCD0001);

        // Dirty lines now: set 0 (tag 4) then set 1 (tag 0), in walk order.
        wb_a = l_0cad;
        wb_a[191:128] = 64'h5555666677778888;
        wb_b = l_beef;
        wb_b[127:64] = 64'h01230000ABCD0001;
        fl_addr[0] = 64'h4000; fl_line[0] = wb_a;
        fl_addr[1] = 64'h40;   fl_line[1] = wb_b;
        wb_cnt = 0;
        fl_done = 0;
        @(negedge clk_in);
        flush_in = 1'b1;
        @(negedge clk_in);
        flush_in = 1'b0;
        for (int cyc = 0; cyc < 1000 && !fl_done; cyc++) begin
            lc_ready_in = 1'b0;
            if (hc_ready_out) begin
                fl_done = 1;
            end else begin
                if (lc_valid_out) begin
                    check_eq("flush we_out", we_out, 1'b1);
                    if (wb_cnt < 2) begin
                        check_eq("flush wb_addr", lc_addr_out, fl_addr[wb_cnt]);
                        check_eq("flush wb_line", lc_value_out, fl_line[wb_cnt]);
                    end
                    wb_cnt++;
                    lc_ready_in = 1'b1;
                end
                @(negedge clk_in);
            end
        end
        lc_ready_in = 1'b0;
        check_eq("flush done", fl_done, 1'b1);
        check_eq("flush wb_count", wb_cnt, 2);
        xact("rd0 after flush", 0, 64'h0, 0, 0, 0, 0, 0, 1, l_fedc, 64'hFEDCBA9876543210);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
